// File: rtl/dbg_mem_bridge.sv
// Debug op bridge: runs one JTAG-side op per synchronised op_ready rising edge and issues single memory accesses.
// Ops take effect SYNC_STAGES+1 cycles after op_ready rises; an access holds req until ack or TIMEOUT, and ops arriving mid-access are dropped.
module dbg_mem_bridge #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int NCH         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_INC    = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              op_ready,
  input  logic [7:0]        op_code,
  input  logic [DW-1:0]     op_data,
  output logic [DW-1:0]     rd_data,
  output logic [7:0]        status,
  output logic              cpu_halt,
  output logic              cpu_reset_req,
  output logic [NCH-1:0]    mem_req,
  output logic [NCH-1:0]    mem_we,
  output logic [NCH*AW-1:0] mem_addr,
  output logic [NCH*DW-1:0] mem_wdata,
  input  logic [NCH*DW-1:0] mem_rdata,
  input  logic [NCH-1:0]    mem_ack
);

  localparam int FW  = $clog2(SYNC_STAGES + 2);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0]  FILL_DONE = FW'(SYNC_STAGES + 1);
  localparam logic [TCW-1:0] TC_LAST   = TCW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic [FW-1:0]          fill_q, fill_d;
  logic [2:0]             ch_q, ch_d;
  logic                   wr_q, wr_d;
  logic [TCW-1:0]         tcnt_q, tcnt_d;
  logic [2:0]             rst_cnt_q, rst_cnt_d;
  logic                   halt_q, halt_d;
  logic                   autoinc_q, autoinc_d;
  logic                   to_q, to_d, bad_q, bad_d, ovr_q, ovr_d;
  logic [DW-1:0]          rd_q, rd_d;
  logic [AW-1:0]          addr_q [NCH];
  logic [AW-1:0]          addr_d [NCH];
  logic [DW-1:0]          wdata_q [NCH];
  logic [DW-1:0]          wdata_d [NCH];

  logic          sync_out, exec, busy, ch_ok;
  logic          is_read, is_write, is_sa, is_sw, mem_op, known, go;
  logic [2:0]    op_c;
  logic          ack_sel;
  logic [DW-1:0] rdata_sel;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Edges are ignored until the chain has refilled after reset, so a level already high at release never fires.
  assign exec     = (fill_q == FILL_DONE) && sync_out && !prev_q;
  assign busy     = (state_q == ISSUE);
  assign op_c     = op_code[2:0];
  assign ch_ok    = ({29'd0, op_c} < 32'(NCH));
  assign is_read  = (op_code[7:3] == 5'b00010);
  assign is_write = (op_code[7:3] == 5'b00100);
  assign is_sa    = (op_code[7:3] == 5'b10000);
  assign is_sw    = (op_code[7:3] == 5'b10010);
  assign mem_op   = is_read | is_write | is_sa | is_sw;
  assign known    = (op_code <= 8'h04) | (op_code == 8'hA0) | mem_op;
  assign go       = exec & mem_op & ch_ok & !busy;

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    mem_req   = '0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int c = 0; c < NCH; c++) begin
      mem_addr[c*AW +: AW]  = addr_q[c];
      mem_wdata[c*DW +: DW] = wdata_q[c];
      if (ch_q == 3'(c)) begin
        ack_sel    = mem_ack[c];
        rdata_sel  = mem_rdata[c*DW +: DW];
        mem_req[c] = busy;
        mem_we[c]  = busy & wr_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], op_ready};
    fill_d    = (fill_q == FILL_DONE) ? fill_q : fill_q + FW'(1);
    ch_d      = ch_q;
    wr_d      = wr_q;
    tcnt_d    = tcnt_q;
    rst_cnt_d = (rst_cnt_q != 3'd0) ? rst_cnt_q - 3'd1 : 3'd0;
    halt_d    = halt_q;
    autoinc_d = autoinc_q;
    to_d      = to_q;
    bad_d     = bad_q | (exec & (!known | (mem_op & !ch_ok)));
    ovr_d     = ovr_q | (exec & mem_op & ch_ok & busy);
    rd_d      = rd_q;
    for (int c = 0; c < NCH; c++) begin
      addr_d[c]  = addr_q[c];
      wdata_d[c] = wdata_q[c];
    end

    if (exec) begin
      if (op_code == 8'h01) halt_d = 1'b1;
      if (op_code == 8'h02) halt_d = 1'b0;
      if (op_code == 8'h03) rst_cnt_d = 3'd4;
      if (op_code == 8'hA0) autoinc_d = op_data[0];
    end

    case (state_q)
      IDLE: begin
        if (go && (is_read || is_write)) begin
          state_d = ISSUE;
          ch_d    = op_c;
          wr_d    = is_write;
          tcnt_d  = '0;
        end
      end
      ISSUE: begin
        if (ack_sel) begin
          state_d = IDLE;
          if (!wr_q) rd_d = rdata_sel;
        end else if (tcnt_q == TC_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    for (int c = 0; c < NCH; c++) begin
      if (go && op_c == 3'(c)) begin
        if (is_sa) addr_d[c]  = op_data[AW-1:0];
        if (is_sw) wdata_d[c] = op_data;
      end
      if (busy && ack_sel && autoinc_q && ch_q == 3'(c))
        addr_d[c] = addr_q[c] + AW'(ADDR_INC);
    end

    // Clear is applied last so it beats a flag set in the same cycle.
    if (exec && op_code == 8'h04) begin
      to_d  = 1'b0;
      bad_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      fill_q    <= '0;
      ch_q      <= '0;
      wr_q      <= 1'b0;
      tcnt_q    <= '0;
      rst_cnt_q <= '0;
      halt_q    <= 1'b0;
      autoinc_q <= 1'b0;
      to_q      <= 1'b0;
      bad_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rd_q      <= '0;
      for (int c = 0; c < NCH; c++) begin
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= sync_out;
      fill_q    <= fill_d;
      ch_q      <= ch_d;
      wr_q      <= wr_d;
      tcnt_q    <= tcnt_d;
      rst_cnt_q <= rst_cnt_d;
      halt_q    <= halt_d;
      autoinc_q <= autoinc_d;
      to_q      <= to_d;
      bad_q     <= bad_d;
      ovr_q     <= ovr_d;
      rd_q      <= rd_d;
      for (int c = 0; c < NCH; c++) begin
        addr_q[c]  <= addr_d[c];
        wdata_q[c] <= wdata_d[c];
      end
    end
  end

  assign rd_data       = rd_q;
  assign cpu_halt      = halt_q;
  assign cpu_reset_req = (rst_cnt_q != 3'd0);
  assign status        = {3'b000, halt_q, ovr_q, bad_q, to_q, busy};

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Directed bench for dbg_mem_bridge: each task drives one scenario and checks outputs at the falling edge.
module tb_dbg_mem_bridge;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NCH = 2;

  logic              cpu_clk = 1'b0;
  logic              cpu_rstn = 1'b0;
  logic              op_ready = 1'b0;
  logic [7:0]        op_code = 8'h00;
  logic [DW-1:0]     op_data = '0;
  logic [DW-1:0]     rd_data;
  logic [7:0]        status;
  logic              cpu_halt;
  logic              cpu_reset_req;
  logic [NCH-1:0]    mem_req;
  logic [NCH-1:0]    mem_we;
  logic [NCH*AW-1:0] mem_addr;
  logic [NCH*DW-1:0] mem_wdata;
  logic [NCH*DW-1:0] mem_rdata = '0;
  logic [NCH-1:0]    mem_ack = '0;

  int n_chk  = 0;
  int n_pass = 0;

  dbg_mem_bridge #(
    .DW(DW), .AW(AW), .NCH(NCH), .SYNC_STAGES(2), .ADDR_INC(4), .TIMEOUT(8)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .op_ready(op_ready), .op_code(op_code),
    .op_data(op_data), .rd_data(rd_data), .status(status), .cpu_halt(cpu_halt),
    .cpu_reset_req(cpu_reset_req), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Called at a falling edge; returns at the falling edge of the cycle after the op executed.
  task automatic send_op(input logic [7:0] code, input logic [31:0] data);
    op_code  = code;
    op_data  = data;
    op_ready = 1'b1;
    @(negedge cpu_clk);
    op_ready = 1'b0;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic test_reset();
    cpu_rstn = 1'b0;
    repeat (3) @(negedge cpu_clk);
    n_chk++; if (mem_req !== 2'b00) $display("FAIL rst_req: got %b exp 00", mem_req); else n_pass++;
    n_chk++; if (status !== 8'h00) $display("FAIL rst_status: got %h exp 00", status); else n_pass++;
    n_chk++; if (rd_data !== 32'h0) $display("FAIL rst_rd_data: got %h exp 0", rd_data); else n_pass++;
    n_chk++; if (cpu_halt !== 1'b0 || cpu_reset_req !== 1'b0)
      $display("FAIL rst_halt_rr: got %b%b exp 00", cpu_halt, cpu_reset_req); else n_pass++;
    n_chk++; if (mem_addr !== 64'h0) $display("FAIL rst_addr: got %h exp 0", mem_addr); else n_pass++;
    cpu_rstn = 1'b1;
    repeat (5) @(negedge cpu_clk);
  endtask

  task automatic test_write();
    send_op(8'h80, 32'h0000_0100);
    send_op(8'h90, 32'hDEAD_BEEF);
    send_op(8'h20, 32'h0);
    n_chk++; if (mem_req !== 2'b01) $display("FAIL wr_req: got %b exp 01", mem_req); else n_pass++;
    n_chk++; if (mem_we !== 2'b01) $display("FAIL wr_we: got %b exp 01", mem_we); else n_pass++;
    n_chk++; if (mem_addr[31:0] !== 32'h100) $display("FAIL wr_addr: got %h exp 100", mem_addr[31:0]); else n_pass++;
    n_chk++; if (mem_wdata[31:0] !== 32'hDEADBEEF)
      $display("FAIL wr_wdata: got %h exp deadbeef", mem_wdata[31:0]); else n_pass++;
    n_chk++; if (status !== 8'h01) $display("FAIL wr_busy: got %h exp 01", status); else n_pass++;
    repeat (2) begin
      @(negedge cpu_clk);
      n_chk++; if (mem_req !== 2'b01 || mem_we !== 2'b01)
        $display("FAIL wr_hold: got req %b we %b exp 01 01", mem_req, mem_we); else n_pass++;
    end
    mem_ack = 2'b01;
    @(negedge cpu_clk);
    mem_ack = 2'b00;
    n_chk++; if (mem_req !== 2'b00 || mem_we !== 2'b00)
      $display("FAIL wr_drop: got req %b we %b exp 00 00", mem_req, mem_we); else n_pass++;
    n_chk++; if (status !== 8'h00) $display("FAIL wr_done_status: got %h exp 00", status); else n_pass++;
    n_chk++; if (mem_addr[31:0] !== 32'h100) $display("FAIL wr_noinc: got %h exp 100", mem_addr[31:0]); else n_pass++;
  endtask

  task automatic test_autoinc_read();
    send_op(8'hA0, 32'h1);
    send_op(8'h81, 32'hFFFF_FFFC);
    send_op(8'h11, 32'h0);
    n_chk++; if (mem_req !== 2'b10 || mem_we !== 2'b00)
      $display("FAIL rd1_req: got req %b we %b exp 10 00", mem_req, mem_we); else n_pass++;
    n_chk++; if (mem_addr[63:32] !== 32'hFFFFFFFC)
      $display("FAIL rd1_addr: got %h exp fffffffc", mem_addr[63:32]); else n_pass++;
    mem_rdata[63:32] = 32'h11;
    mem_ack = 2'b10;
    @(negedge cpu_clk);
    mem_ack = 2'b00;
    n_chk++; if (rd_data !== 32'h11) $display("FAIL rd1_data: got %h exp 11", rd_data); else n_pass++;
    n_chk++; if (mem_req !== 2'b00) $display("FAIL rd1_drop: got %b exp 00", mem_req); else n_pass++;
    n_chk++; if (mem_addr[63:32] !== 32'h0) $display("FAIL rd1_wrap: got %h exp 0", mem_addr[63:32]); else n_pass++;
    send_op(8'h11, 32'h0);
    mem_rdata[63:32] = 32'h22;
    mem_ack = 2'b10;
    @(negedge cpu_clk);
    mem_ack = 2'b00;
    n_chk++; if (rd_data !== 32'h22) $display("FAIL rd2_data: got %h exp 22", rd_data); else n_pass++;
    n_chk++; if (mem_addr[63:32] !== 32'h4) $display("FAIL rd2_inc: got %h exp 4", mem_addr[63:32]); else n_pass++;
    n_chk++; if (mem_addr[31:0] !== 32'h100) $display("FAIL rd2_ch0: got %h exp 100", mem_addr[31:0]); else n_pass++;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    int guard = 0;
    send_op(8'h10, 32'h0);
    while (mem_req[0] === 1'b1 && guard < 40) begin
      cnt++;
      guard++;
      @(negedge cpu_clk);
    end
    n_chk++; if (cnt != 8) $display("FAIL to_cycles: got %0d exp 8", cnt); else n_pass++;
    n_chk++; if (status !== 8'h02) $display("FAIL to_status: got %h exp 02", status); else n_pass++;
    n_chk++; if (rd_data !== 32'h22) $display("FAIL to_rd_kept: got %h exp 22", rd_data); else n_pass++;
    n_chk++; if (mem_addr[31:0] !== 32'h100) $display("FAIL to_addr_kept: got %h exp 100", mem_addr[31:0]); else n_pass++;
    send_op(8'h04, 32'h0);
    n_chk++; if (status !== 8'h00) $display("FAIL to_clear: got %h exp 00", status); else n_pass++;
  endtask

  task automatic test_overrun();
    int guard = 0;
    send_op(8'h10, 32'h0);
    n_chk++; if (mem_req !== 2'b01) $display("FAIL ov_req: got %b exp 01", mem_req); else n_pass++;
    send_op(8'h21, 32'h0);
    n_chk++; if (status !== 8'h09) $display("FAIL ov_status: got %h exp 09", status); else n_pass++;
    n_chk++; if (mem_req !== 2'b01 || mem_we !== 2'b00)
      $display("FAIL ov_dropped: got req %b we %b exp 01 00", mem_req, mem_we); else n_pass++;
    send_op(8'h01, 32'h0);
    n_chk++; if (cpu_halt !== 1'b1) $display("FAIL ov_halt: got %b exp 1", cpu_halt); else n_pass++;
    n_chk++; if (mem_req !== 2'b01) $display("FAIL ov_req_during_halt: got %b exp 01", mem_req); else n_pass++;
    n_chk++; if (status !== 8'h19) $display("FAIL ov_status_halt: got %h exp 19", status); else n_pass++;
    while (mem_req !== 2'b00 && guard < 40) begin
      guard++;
      @(negedge cpu_clk);
    end
    n_chk++; if (status !== 8'h1A) $display("FAIL ov_final: got %h exp 1a", status); else n_pass++;
    send_op(8'h02, 32'h0);
    n_chk++; if (cpu_halt !== 1'b0) $display("FAIL ov_resume: got %b exp 0", cpu_halt); else n_pass++;
    send_op(8'h04, 32'h0);
    n_chk++; if (status !== 8'h00) $display("FAIL ov_clear: got %h exp 00", status); else n_pass++;
  endtask

  task automatic test_bad_op_and_reset_pulse();
    int cnt = 0;
    int guard = 0;
    send_op(8'h27, 32'h0);
    n_chk++; if (mem_req !== 2'b00) $display("FAIL bad_req: got %b exp 00", mem_req); else n_pass++;
    n_chk++; if (status !== 8'h04) $display("FAIL bad_status: got %h exp 04", status); else n_pass++;
    send_op(8'h04, 32'h0);
    send_op(8'h3F, 32'h0);
    n_chk++; if (status !== 8'h04) $display("FAIL undef_status: got %h exp 04", status); else n_pass++;
    send_op(8'h04, 32'h0);
    send_op(8'h03, 32'h0);
    while (cpu_reset_req === 1'b1 && guard < 20) begin
      cnt++;
      guard++;
      @(negedge cpu_clk);
    end
    n_chk++; if (cnt != 4) $display("FAIL rr_len: got %0d exp 4", cnt); else n_pass++;
    send_op(8'h03, 32'h0);
    send_op(8'h03, 32'h0);
    cnt = 0;
    guard = 0;
    while (cpu_reset_req === 1'b1 && guard < 20) begin
      cnt++;
      guard++;
      @(negedge cpu_clk);
    end
    n_chk++; if (cnt != 4) $display("FAIL rr_restart: got %0d exp 4", cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_issue();
    send_op(8'h11, 32'h0);
    n_chk++; if (mem_req !== 2'b10 || mem_addr[63:32] !== 32'h4)
      $display("FAIL mr_issue: got req %b addr %h exp 10 4", mem_req, mem_addr[63:32]); else n_pass++;
    op_code  = 8'h01;
    op_ready = 1'b1;
    #2;
    cpu_rstn = 1'b0;
    #1;
    n_chk++; if (mem_req !== 2'b00 || mem_we !== 2'b00)
      $display("FAIL mr_req_async: got req %b we %b exp 00 00", mem_req, mem_we); else n_pass++;
    n_chk++; if (status !== 8'h00 || rd_data !== 32'h0)
      $display("FAIL mr_state: got status %h rd %h exp 00 0", status, rd_data); else n_pass++;
    n_chk++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0)
      $display("FAIL mr_regs: got addr %h wdata %h exp 0 0", mem_addr, mem_wdata); else n_pass++;
    repeat (2) @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    repeat (8) @(negedge cpu_clk);
    n_chk++; if (cpu_halt !== 1'b0 || status !== 8'h00)
      $display("FAIL mr_no_exec: got halt %b status %h exp 0 00", cpu_halt, status); else n_pass++;
    op_ready = 1'b0;
    @(negedge cpu_clk);
    send_op(8'h01, 32'h0);
    n_chk++; if (cpu_halt !== 1'b1) $display("FAIL mr_new_edge: got %b exp 1", cpu_halt); else n_pass++;
  endtask

  initial begin
    @(negedge cpu_clk);
    test_reset();
    test_write();
    test_autoinc_read();
    test_timeout();
    test_overrun();
    test_bad_op_and_reset_pulse();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
